// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and constants for the instruction decode stage
package decode_pkg;

  localparam int DATA_W = 32;
  localparam int DIR_W  = 5;

  localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_B_TYPE = 7'b1100011;
  localparam logic [6:0] OPCODE_J_TYPE = 7'b1101111;
  localparam logic [2:0] FUNCT3_ZERO   = 3'b000;
  localparam logic [6:0] FUNCT7_ADD    = 7'b0000000;

  typedef enum logic [2:0] {
    OP_ADDI    = 3'd0,
    OP_ADD     = 3'd1,
    OP_BEQ     = 3'd2,
    OP_JAL     = 3'd3,
    OP_ILLEGAL = 3'd4
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [DIR_W-1:0]  rd;
    logic [DIR_W-1:0]  rs1;
    logic [DIR_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              reg_write;
  } decoded_s;

  function automatic decoded_s empty_entry();
    decoded_s d;
    d           = '0;
    d.op        = OP_ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational split of an instruction word into decoded fields
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  output decoded_s          dec
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [DIR_W-1:0] rd;
  logic [DIR_W-1:0] rs1;
  logic [DIR_W-1:0] rs2;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Fields not used by an op stay at zero from the empty entry.
  always_comb begin
    dec    = empty_entry();
    dec.pc = pc;
    case (opcode)
      OPCODE_I_TYPE: if (funct3 == FUNCT3_ZERO) begin
        dec.op        = OP_ADDI;
        dec.rd        = rd;
        dec.rs1       = rs1;
        dec.imm       = {{(DATA_W-12){instr[31]}}, instr[31:20]};
        dec.reg_write = (rd != '0);
      end
      OPCODE_R_TYPE: if (funct3 == FUNCT3_ZERO && funct7 == FUNCT7_ADD) begin
        dec.op        = OP_ADD;
        dec.rd        = rd;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.reg_write = (rd != '0);
      end
      OPCODE_B_TYPE: if (funct3 == FUNCT3_ZERO) begin
        dec.op  = OP_BEQ;
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.imm = {{(DATA_W-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
      end
      OPCODE_J_TYPE: begin
        dec.op        = OP_JAL;
        dec.rd        = rd;
        dec.imm       = {{(DATA_W-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
        dec.reg_write = (rd != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered decode stage with 2-entry skid buffer and statistics
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIR_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output op_e                   out_op,
  output logic [DIR_WIDTH-1:0]  out_rd,
  output logic [DIR_WIDTH-1:0]  out_rs1,
  output logic [DIR_WIDTH-1:0]  out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_reg_write,
  output logic [CNT_WIDTH-1:0]  cnt_decoded,
  output logic [CNT_WIDTH-1:0]  cnt_illegal
);

  decoded_s dec_in;
  decoded_s main_q, main_d, skid_q, skid_d;
  logic     main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic     in_fire, out_fire;

  instr_field_decode u_field_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_in)
  );

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

  // in_ready is only high when the skid is empty, so an accepted word never overwrites it.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire) begin
        main_valid_d = skid_valid_q;
        main_d       = skid_valid_q ? skid_q : main_q;
        skid_valid_d = 1'b0;
      end
      if (in_fire) begin
        if (main_valid_q && !out_fire) begin
          skid_d       = dec_in;
          skid_valid_d = 1'b1;
        end else begin
          main_d       = dec_in;
          main_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      main_q       <= empty_entry();
      skid_q       <= empty_entry();
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready     <= 1'b0;
      cnt_decoded  <= '0;
      cnt_illegal  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready     <= !skid_valid_d;
      if (out_fire && !flush) begin
        if (main_q.op == OP_ILLEGAL) begin
          if (cnt_illegal != '1) cnt_illegal <= cnt_illegal + 1'b1;
        end else begin
          if (cnt_decoded != '1) cnt_decoded <= cnt_decoded + 1'b1;
        end
      end
    end
  end

  assign out_valid     = main_valid_q;
  assign out_op        = main_q.op;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_imm       = main_q.imm;
  assign out_pc        = main_q.pc;
  assign out_reg_write = main_q.reg_write;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;
  import decode_pkg::*;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_instr = '0;
  logic [31:0]       in_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  op_e               out_op;
  logic [4:0]        out_rd, out_rs1, out_rs2;
  logic [31:0]       out_imm, out_pc;
  logic              out_reg_write;
  logic [CNT_W-1:0]  cnt_decoded, cnt_illegal;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_dec = 0;
  int   m_ill = 0;

  instr_decode_stage #(.DATA_WIDTH(32), .DIR_WIDTH(5), .CNT_WIDTH(CNT_W)) dut (
    .clk           (clk),
    .arst          (arst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .out_pc        (out_pc),
    .out_reg_write (out_reg_write),
    .cnt_decoded   (cnt_decoded),
    .cnt_illegal   (cnt_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input op_e op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic rw);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    cur      = '{op, rd, rs1, rs2, imm, pc, rw};
  endtask

  // Called at a falling edge: score this cycle's handshakes, then advance one cycle.
  task automatic tick();
    exp_t e;
    logic inf, outf;
    chk("cnt_decoded", 32'(cnt_decoded), m_dec);
    chk("cnt_illegal", 32'(cnt_illegal), m_ill);
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    if (flush) begin
      sb.delete();
    end else begin
      if (outf) begin
        chk("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_op", 32'(out_op), 32'(e.op));
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_rs1", 32'(out_rs1), 32'(e.rs1));
          chk("out_rs2", 32'(out_rs2), 32'(e.rs2));
          chk("out_imm", out_imm, e.imm);
          chk("out_pc", out_pc, e.pc);
          chk("out_reg_write", 32'(out_reg_write), 32'(e.rw));
          if (e.op == OP_ILLEGAL) m_ill = (m_ill == CNT_MAX) ? CNT_MAX : m_ill + 1;
          else                    m_dec = (m_dec == CNT_MAX) ? CNT_MAX : m_dec + 1;
        end
      end
      if (inf) sb.push_back(cur);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_op"}, 32'(out_op), 32'(OP_ILLEGAL));
    chk({tag, "_out_rd"}, 32'(out_rd), 0);
    chk({tag, "_out_imm"}, out_imm, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_out_reg_write"}, 32'(out_reg_write), 0);
    chk({tag, "_cnt_decoded"}, 32'(cnt_decoded), 0);
    chk({tag, "_cnt_illegal"}, 32'(cnt_illegal), 0);
  endtask

  initial begin
    #1 arst = 1'b1;
    #2 chk_reset_outputs("reset");
    @(negedge clk);
    arst = 1'b0;
    chk("in_ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_release", 32'(in_ready), 1);

    // Single ADDI: one-cycle latency, then handed off.
    out_ready = 1'b1;
    offer(32'h00100293, 32'h0000_0000, OP_ADDI, 5, 0, 0, 32'h1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("latency_out_valid", 32'(out_valid), 1);
    tick();
    tick();
    chk("cnt_after_addi", 32'(cnt_decoded), 1);

    // Back-to-back stream, one word per cycle.
    offer(32'h006283B3, 32'h0000_0004, OP_ADD, 7, 5, 6, 32'h0, 1'b1);
    tick();
    offer(32'hFE208CE3, 32'h0000_0008, OP_BEQ, 0, 1, 2, 32'hFFFF_FFF8, 1'b0);
    tick();
    chk("stream_out_valid", 32'(out_valid), 1);
    offer(32'h001000EF, 32'h0000_000C, OP_JAL, 1, 0, 0, 32'h0000_0800, 1'b1);
    tick();
    offer(32'h00000013, 32'h0000_0010, OP_ADDI, 0, 0, 0, 32'h0, 1'b0);
    tick();
    offer(32'hFFF00293, 32'h0000_0014, OP_ADDI, 5, 0, 0, 32'hFFFF_FFFF, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_drained", sb.size(), 0);

    // Backpressure: three words offered while the consumer stalls.
    out_ready = 1'b0;
    offer(32'h00100293, 32'h0000_0100, OP_ADDI, 5, 0, 0, 32'h1, 1'b1);
    tick();
    offer(32'h006283B3, 32'h0000_0104, OP_ADD, 7, 5, 6, 32'h0, 1'b1);
    tick();
    offer(32'hFE208CE3, 32'h0000_0108, OP_BEQ, 0, 1, 2, 32'hFFFF_FFF8, 1'b0);
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_first_on_out", out_pc, 32'h0000_0100);
    tick();
    chk("stall_held_pc", out_pc, 32'h0000_0100);
    chk("stall_in_ready2", 32'(in_ready), 0);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("stall_drained", sb.size(), 0);

    // Illegal encoding (SUB).
    offer(32'h40000033, 32'h0000_0200, OP_ILLEGAL, 0, 0, 0, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("cnt_illegal_one", 32'(cnt_illegal), 1);
    chk("cnt_decoded_unchanged", 32'(cnt_decoded), 9);

    // Saturation of the decoded counter.
    for (int i = 0; i < 10; i++) begin
      offer(32'h00100293, 32'h0000_0300 + 32'(4 * i), OP_ADDI, 5, 0, 0, 32'h1, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("cnt_decoded_saturated", 32'(cnt_decoded), CNT_MAX);

    // Flush of a full, stalled stage with a word presented.
    out_ready = 1'b0;
    offer(32'h00100293, 32'h0000_0400, OP_ADDI, 5, 0, 0, 32'h1, 1'b1);
    tick();
    offer(32'h006283B3, 32'h0000_0404, OP_ADD, 7, 5, 6, 32'h0, 1'b1);
    tick();
    offer(32'h001000EF, 32'h0000_0408, OP_JAL, 1, 0, 0, 32'h0000_0800, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_output", 32'(out_valid), 0);

    // Asynchronous reset while stalled and full.
    out_ready = 1'b0;
    offer(32'h00100293, 32'h0000_0500, OP_ADDI, 5, 0, 0, 32'h1, 1'b1);
    tick();
    offer(32'hFE208CE3, 32'h0000_0504, OP_BEQ, 0, 1, 2, 32'hFFFF_FFF8, 1'b0);
    tick();
    in_valid = 1'b0;
    #2 arst = 1'b1;
    #1 chk_reset_outputs("arst_mid");
    sb.delete();
    m_dec = 0;
    m_ill = 0;
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    offer(32'h001000EF, 32'h0000_0600, OP_JAL, 1, 0, 0, 32'h0000_0800, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
